// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Merges ALU and load (mem) writeback requests into a single register-file
//   write port through a small in-order pending-write queue. Loads win over
//   the ALU when both request in the same cycle. Writes to register 0 are
//   acknowledged but dropped. Pending entries can be looked up by two read
//   addresses so the read stage can forward not-yet-written data.
//
//   Ports
//     clock, reset            : clock, synchronous active-high reset
//     alu_valid/addr/data     : ALU writeback request       -> alu_ready
//     mem_valid/addr/data     : load writeback request      -> mem_ready
//     rf_write_enable/address/data : register file write port (head entry)
//     fwd_address1/2          : read addresses to look up in the queue
//     fwd_hit1/2, fwd_data1/2 : youngest pending write to that address
//     pending_count, full, empty : queue occupancy
module writeback_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        alu_valid,
    input  logic [ADDR_WIDTH-1:0]       alu_addr,
    input  logic [DATA_WIDTH-1:0]       alu_data,
    output logic                        alu_ready,
    input  logic                        mem_valid,
    input  logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_data,
    output logic                        mem_ready,
    output logic                        rf_write_enable,
    output logic [ADDR_WIDTH-1:0]       rf_write_address,
    output logic [DATA_WIDTH-1:0]       rf_write_data,
    input  logic [ADDR_WIDTH-1:0]       fwd_address1,
    input  logic [ADDR_WIDTH-1:0]       fwd_address2,
    output logic                        fwd_hit1,
    output logic                        fwd_hit2,
    output logic [DATA_WIDTH-1:0]       fwd_data1,
    output logic [DATA_WIDTH-1:0]       fwd_data2,
    output logic [$clog2(DEPTH):0]      pending_count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q;

    logic                  full_int, empty_int;
    logic                  mem_hs, alu_hs;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [DATA_WIDTH-1:0] push_data;

    assign full_int  = (count_q == CNT_W'(DEPTH));
    assign empty_int = (count_q == '0);

    // Readiness depends only on occupancy before this edge, so a pop in the
    // same cycle does not free a slot for a push.
    assign mem_ready = !full_int && !reset;
    assign alu_ready = !full_int && !mem_valid && !reset;

    assign mem_hs = mem_valid && mem_ready;
    assign alu_hs = alu_valid && alu_ready;

    // The two handshakes are mutually exclusive (alu_ready needs !mem_valid).
    assign push_addr = mem_hs ? mem_addr : alu_addr;
    assign push_data = mem_hs ? mem_data : alu_data;
    // Register 0 is hardwired to zero: acknowledge the request, store nothing.
    assign push      = (mem_hs || alu_hs) && (push_addr != '0);
    assign pop       = !empty_int && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                addr_q[tail_q] <= push_addr;
                data_q[tail_q] <= push_data;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rf_write_enable  = pop;
    assign rf_write_address = pop ? addr_q[head_q] : '0;
    assign rf_write_data    = pop ? data_q[head_q] : '0;

    assign pending_count = reset ? '0 : count_q;
    assign full          = full_int && !reset;
    assign empty         = empty_int || reset;

    // Walk occupied entries oldest to youngest; a later match overrides an
    // earlier one so the youngest write wins. The head is still occupied in
    // the cycle it is being written, so it participates.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset && (CNT_W'(i) < count_q)) begin
                if ((fwd_address1 != '0) && (addr_q[head_q + PTR_W'(i)] == fwd_address1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[head_q + PTR_W'(i)];
                end
                if ((fwd_address2 != '0) && (addr_q[head_q + PTR_W'(i)] == fwd_address2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[head_q + PTR_W'(i)];
                end
            end
        end
    end

endmodule
